// File: rtl/vga_screen_sel_if.sv
// vga_screen_sel_if: source/pin bundle for the frame-synchronous VGA source selector.
// master drives the source side (requests, per-source syncs and colour); slave is the selector.
interface vga_screen_sel_if #(
  parameter int unsigned N_SRC   = 3,
  parameter int unsigned COLOR_W = 4
);
  localparam int unsigned AW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]           req;
  logic [N_SRC-1:0]           src_hsync;
  logic [N_SRC-1:0]           src_vsync;
  logic [N_SRC*3*COLOR_W-1:0] src_rgb;
  logic                       hsync;
  logic                       vsync;
  logic [COLOR_W-1:0]         red;
  logic [COLOR_W-1:0]         green;
  logic [COLOR_W-1:0]         blue;
  logic [AW-1:0]              active_src;
  logic                       switching;

  modport master (
    output req, src_hsync, src_vsync, src_rgb,
    input  hsync, vsync, red, green, blue, active_src, switching
  );

  modport slave (
    input  req, src_hsync, src_vsync, src_rgb,
    output hsync, vsync, red, green, blue, active_src, switching
  );
endinterface

// File: rtl/vga_screen_sel.sv
// vga_screen_sel: forwards one of N_SRC VGA generators to the pins, switching only on a vsync
// falling edge of the shown source and then inserting BLANK_FRAMES black frames.
// Optional macro VGA_SCREEN_SEL_STICKY_EN: once a non-zero source is active, lower-index
// requests and request deassertion are ignored until clr.
module vga_screen_sel #(
  parameter int unsigned N_SRC        = 3,
  parameter int unsigned COLOR_W      = 4,
  parameter int unsigned BLANK_FRAMES = 2
) (
  input logic             clk,
  input logic             clr,
  vga_screen_sel_if.slave bus
);
  localparam int unsigned AW    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned RGB_W = 3 * COLOR_W;

  typedef enum logic {StShow, StBlank} state_e;

  state_e           r_state;
  logic [3:0]       r_cnt;
  logic             r_vs_prev;
  logic [AW-1:0]    r_active;
  logic             r_switching;
  logic             r_hsync;
  logic             r_vsync;
  logic [RGB_W-1:0] r_rgb;

  logic [AW-1:0]    w_enc;
  logic [AW-1:0]    w_target;
  logic             w_vs_cur;
  logic             w_boundary;
  logic             w_retarget;

  // Priority encode of the request levels: highest set index wins, else source 0.
  always_comb begin
    w_enc = '0;
    for (int i = 1; i < int'(N_SRC); i++) begin
      if (bus.req[i]) w_enc = AW'(i);
    end
  end

`ifdef VGA_SCREEN_SEL_STICKY_EN
  // Latch a non-default screen: only a higher-index request may take over.
  always_comb begin
    w_target = w_enc;
    if ((r_active != '0) && (w_enc < r_active)) w_target = r_active;
  end
`else
  assign w_target = w_enc;
`endif

  assign w_vs_cur   = bus.src_vsync[r_active];
  assign w_boundary = r_vs_prev & ~w_vs_cur;
  assign w_retarget = w_boundary && (w_target != r_active);

  // Output register stage plus switch/blank sequencing.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= StShow;
      r_cnt       <= 4'd0;
      r_vs_prev   <= 1'b1;
      r_active    <= '0;
      r_switching <= 1'b0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_rgb       <= '0;
    end else begin
      // Sync and colour share one stage so they stay aligned.
      r_hsync   <= bus.src_hsync[r_active];
      r_vsync   <= w_vs_cur;
      r_rgb     <= (r_state == StBlank) ? '0 : bus.src_rgb[int'(r_active)*RGB_W +: RGB_W];
      r_vs_prev <= w_vs_cur;
      if (w_retarget) begin
        r_active  <= w_target;
        // Seed edge history from the new source so its current vsync level is not an edge.
        r_vs_prev <= bus.src_vsync[w_target];
        if (BLANK_FRAMES > 0) begin
          r_state     <= StBlank;
          r_switching <= 1'b1;
          r_cnt       <= 4'(BLANK_FRAMES);
        end
      end else if (w_boundary && (r_state == StBlank)) begin
        if (r_cnt <= 4'd1) begin
          r_cnt       <= 4'd0;
          r_state     <= StShow;
          r_switching <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.red        = r_rgb[RGB_W-1 -: COLOR_W];
  assign bus.green      = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign bus.blue       = r_rgb[COLOR_W-1:0];
  assign bus.active_src = r_active;
  assign bus.switching  = r_switching;
endmodule
